// File: rtl/sha256_round_ctrl.sv
// Sequencing controller for the SHA-256 compression datapath: loads H/working/W
// registers, steps 64 rounds per 512-bit block and presents the final digest.
module sha256_round_ctrl (
   input  logic       CLK,
   input  logic       RST,
   input  logic       abort,
   input  logic       blk_start,
   input  logic       blk_first,
   input  logic       blk_last,
   input  logic       word_valid,
   output logic       word_ready,
   output logic       iv_sel,
   output logic       h_ld,
   output logic       wk_init,
   output logic       wk_ld,
   output logic       w_sel,
   output logic       w_ld,
   output logic [5:0] round,
   output logic       busy,
   output logic       digest_valid,
   input  logic       digest_ready
);

   typedef enum logic [2:0] {
      S_IDLE, S_IV, S_LDWK, S_MSG, S_EXP, S_UPD, S_WAIT, S_DONE
   } state_t;

   state_t     r_state;
   state_t     w_nxt_state;
   logic [5:0] r_round;
   logic [5:0] w_nxt_round;
   logic       r_last_q;
   logic       w_nxt_last;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state  <= S_IDLE;
         r_round  <= 6'd0;
         r_last_q <= 1'b0;
      end else begin
         r_state  <= w_nxt_state;
         r_round  <= w_nxt_round;
         r_last_q <= w_nxt_last;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      w_nxt_state  = r_state;
      w_nxt_round  = r_round;
      w_nxt_last   = r_last_q;
      word_ready   = 1'b0;
      iv_sel       = 1'b0;
      h_ld         = 1'b0;
      wk_init      = 1'b0;
      wk_ld        = 1'b0;
      w_sel        = 1'b0;
      w_ld         = 1'b0;
      digest_valid = 1'b0;

      case (r_state)
         S_IDLE, S_WAIT: begin
            if (blk_start) begin
               w_nxt_last  = blk_last;
               w_nxt_state = blk_first ? S_IV : S_LDWK;
            end
         end
         S_IV: begin
            h_ld        = 1'b1;
            iv_sel      = 1'b1;
            w_nxt_state = S_LDWK;
         end
         S_LDWK: begin
            wk_ld       = 1'b1;
            wk_init     = 1'b1;
            w_nxt_round = 6'd0;
            w_nxt_state = S_MSG;
         end
         S_MSG: begin
            // Without a valid word every enable stays low and the round holds.
            word_ready = 1'b1;
            if (word_valid) begin
               w_ld        = 1'b1;
               wk_ld       = 1'b1;
               w_nxt_round = r_round + 6'd1;
               if (r_round == 6'd15) w_nxt_state = S_EXP;
            end
         end
         S_EXP: begin
            w_ld        = 1'b1;
            w_sel       = 1'b1;
            wk_ld       = 1'b1;
            w_nxt_round = r_round + 6'd1;
            if (r_round == 6'd63) w_nxt_state = S_UPD;
         end
         S_UPD: begin
            h_ld        = 1'b1;
            w_nxt_round = 6'd0;
            w_nxt_state = r_last_q ? S_DONE : S_WAIT;
         end
         S_DONE: begin
            digest_valid = 1'b1;
            if (digest_ready) w_nxt_state = S_IDLE;
         end
         default: w_nxt_state = S_IDLE;
      endcase

      if (abort) begin
         word_ready   = 1'b0;
         iv_sel       = 1'b0;
         h_ld         = 1'b0;
         wk_init      = 1'b0;
         wk_ld        = 1'b0;
         w_sel        = 1'b0;
         w_ld         = 1'b0;
         digest_valid = 1'b0;
         w_nxt_state  = S_IDLE;
         w_nxt_round  = 6'd0;
      end
   end

   assign round = r_round;
   assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl: directed timing scenarios plus random traffic,
// every cycle compared against a plan-queue reference model.
module tb_sha256_round_ctrl;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       abort = 1'b0;
   logic       blk_start = 1'b0;
   logic       blk_first = 1'b0;
   logic       blk_last = 1'b0;
   logic       word_valid = 1'b0;
   logic       digest_ready = 1'b0;
   logic       word_ready, iv_sel, h_ld, wk_init, wk_ld, w_sel, w_ld;
   logic [5:0] round;
   logic       busy, digest_valid;

   int n_checks = 0;
   int n_errors = 0;

   sha256_round_ctrl dut (
      .CLK(CLK), .RST(RST), .abort(abort), .blk_start(blk_start),
      .blk_first(blk_first), .blk_last(blk_last), .word_valid(word_valid),
      .word_ready(word_ready), .iv_sel(iv_sel), .h_ld(h_ld), .wk_init(wk_init),
      .wk_ld(wk_ld), .w_sel(w_sel), .w_ld(w_ld), .round(round), .busy(busy),
      .digest_valid(digest_valid), .digest_ready(digest_ready)
   );

   always #5 CLK = ~CLK;

   wire logic [14:0] w_obs = {word_ready, iv_sel, h_ld, wk_init, wk_ld, w_sel,
                              w_ld, busy, digest_valid, round};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // Reference model: a block is a script of steps queued when it is accepted;
   // an empty script means the controller rests in idle, wait or done.
   localparam int P_IV = 0, P_LD = 1, P_MSG = 2, P_EXP = 3, P_UPD = 4;
   localparam int R_IDLE = 0, R_WAIT = 1, R_DONE = 2;
   int plan[$];
   int m_rest = R_IDLE;
   int m_rounds = 0;

   always @(negedge CLK) begin
      logic e_wr, e_iv, e_h, e_wi, e_wk, e_ws, e_wl, e_busy, e_dv;
      logic [14:0] e_vec;
      if (RST) begin
         plan.delete();
         m_rest   = R_IDLE;
         m_rounds = 0;
         check("rst_outs", {17'd0, w_obs}, 32'd0);
      end else begin
         {e_wr, e_iv, e_h, e_wi, e_wk, e_ws, e_wl, e_busy, e_dv} = '0;
         if (plan.size() > 0) begin
            e_busy = 1'b1;
            case (plan[0])
               P_IV:  begin e_h = 1'b1; e_iv = 1'b1; end
               P_LD:  begin e_wk = 1'b1; e_wi = 1'b1; end
               P_MSG: begin e_wr = 1'b1; e_wl = word_valid; e_wk = word_valid; end
               P_EXP: begin e_wl = 1'b1; e_ws = 1'b1; e_wk = 1'b1; end
               default: e_h = 1'b1;
            endcase
         end else begin
            e_busy = (m_rest != R_IDLE);
            e_dv   = (m_rest == R_DONE);
         end
         if (abort) {e_wr, e_iv, e_h, e_wi, e_wk, e_ws, e_wl, e_dv} = '0;
         e_vec = {e_wr, e_iv, e_h, e_wi, e_wk, e_ws, e_wl, e_busy, e_dv, 6'(m_rounds % 64)};
         check("outs", {17'd0, w_obs}, {17'd0, e_vec});

         if (abort) begin
            plan.delete();
            m_rest   = R_IDLE;
            m_rounds = 0;
         end else if (plan.size() > 0) begin
            if (plan[0] == P_MSG) begin
               if (word_valid) begin void'(plan.pop_front()); m_rounds++; end
            end else begin
               if (plan[0] == P_EXP) m_rounds++;
               void'(plan.pop_front());
            end
         end else if (m_rest == R_DONE) begin
            if (digest_ready) m_rest = R_IDLE;
         end else if (blk_start) begin
            m_rounds = 0;
            if (blk_first) plan.push_back(P_IV);
            plan.push_back(P_LD);
            for (int i = 0; i < 16; i++) plan.push_back(P_MSG);
            for (int i = 0; i < 48; i++) plan.push_back(P_EXP);
            plan.push_back(P_UPD);
            m_rest = blk_last ? R_DONE : R_WAIT;
         end
      end
   end

   // Drive point: one time unit after the rising edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Runs one block from its blk_start cycle (cycle 0) through the update
   // cycle, then samples the resting state one cycle later.
   task automatic run_block(input logic first, input logic last, input logic stall,
                            output int upd_cyc, output int iv_cyc, output int wk_cnt,
                            output int h_cnt, output int iv_cnt, output int wr_first,
                            output int wr_last, output logic post_busy, output logic post_dv);
      int  cyc = 0;
      int  st4 = 0, st15 = 0;
      bit  done = 0;
      upd_cyc = -1; iv_cyc = -1; wk_cnt = 0; h_cnt = 0; iv_cnt = 0;
      wr_first = -1; wr_last = -1;
      blk_start = 1'b1; blk_first = first; blk_last = last;
      word_valid = 1'b1; digest_ready = 1'b0; abort = 1'b0;
      while (!done && cyc < 400) begin
         if (cyc > 0) begin
            blk_start  = 1'b0;
            word_valid = 1'b1;
            if (stall && word_ready && round == 6'd4 && st4 < 3) begin
               word_valid = 1'b0; st4++;
            end
            if (stall && word_ready && round == 6'd15 && st15 < 3) begin
               word_valid = 1'b0; st15++;
            end
         end
         @(negedge CLK);
         if (wk_ld) wk_cnt++;
         if (h_ld) h_cnt++;
         if (iv_sel) iv_cnt++;
         if (h_ld && iv_sel && iv_cyc < 0) iv_cyc = cyc;
         if (word_ready) begin
            if (wr_first < 0) wr_first = cyc;
            wr_last = cyc;
         end
         if (h_ld && !iv_sel) begin upd_cyc = cyc; done = 1; end
         tick();
         cyc++;
      end
      if (!done) check("block_timeout", 32'd0, 32'd1);
      blk_start = 1'b0;
      @(negedge CLK);
      post_busy = busy;
      post_dv   = digest_valid;
      tick();
   endtask

   task automatic release_done();
      digest_ready = 1'b1;
      tick();
      digest_ready = 1'b0;
   endtask

   task automatic start_and_reach(input logic [5:0] r);
      int n = 0;
      blk_start = 1'b1; blk_first = 1'b1; blk_last = 1'b1; word_valid = 1'b1;
      tick();
      blk_start = 1'b0;
      while (round != r && n < 200) begin tick(); n++; end
      if (n == 200) check("reach_timeout", 32'd0, 32'd1);
   endtask

   int   upd, ivc, wkc, hc, ivn, wrf, wrl;
   logic pb, pd;

   initial begin
      tick(); tick();
      check("reset_outs", {17'd0, w_obs}, 32'd0);
      @(posedge CLK); #2 RST = 1'b0;
      tick();

      // Single block, words back-to-back.
      run_block(1, 1, 0, upd, ivc, wkc, hc, ivn, wrf, wrl, pb, pd);
      check("s1_iv_cycle", ivc, 1);
      check("s1_wr_first", wrf, 3);
      check("s1_wr_last", wrl, 18);
      check("s1_wk_count", wkc, 65);
      check("s1_dv_cycle", pd ? upd + 1 : -1, 68);

      // Digest held while the consumer stalls; blk_start ignored meanwhile.
      for (int i = 0; i < 10; i++) begin
         digest_ready = 1'b0;
         blk_start = 1'($urandom);
         blk_first = 1'($urandom);
         @(negedge CLK);
         check("done_hold_dv", digest_valid, 1);
         tick();
      end
      blk_start = 1'b0;
      digest_ready = 1'b1;
      tick();
      digest_ready = 1'b0;
      check("done_exit_busy", busy, 0);

      // Single block with two three-cycle stalls.
      run_block(1, 1, 1, upd, ivc, wkc, hc, ivn, wrf, wrl, pb, pd);
      check("s2_wk_count", wkc, 65);
      check("s2_dv_cycle", pd ? upd + 1 : -1, 74);
      release_done();

      // Two-block message.
      run_block(1, 0, 0, upd, ivc, wkc, hc, ivn, wrf, wrl, pb, pd);
      check("b1_upd", upd, 67);
      check("b1_h_count", hc, 2);
      check("b1_wait_busy", pb, 1);
      check("b1_wait_dv", pd, 0);
      run_block(0, 1, 0, upd, ivc, wkc, hc, ivn, wrf, wrl, pb, pd);
      check("b2_upd", upd, 66);
      check("b2_h_count", hc, 1);
      check("b2_iv_count", ivn, 0);
      check("b2_dv", pd, 1);
      release_done();

      // Abort mid-expansion.
      start_and_reach(6'd40);
      abort = 1'b1;
      #1;
      check("abort_enables", {h_ld, wk_ld, w_ld, word_ready, digest_valid, iv_sel, wk_init, w_sel}, 0);
      tick();
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_round", round, 0);
      run_block(1, 1, 0, upd, ivc, wkc, hc, ivn, wrf, wrl, pb, pd);
      check("abort_rerun_dv", pd ? upd + 1 : -1, 68);
      release_done();

      // Asynchronous reset between edges during expansion.
      start_and_reach(6'd30);
      #2 RST = 1'b1;
      #1;
      check("async_rst_outs", {17'd0, w_obs}, 32'd0);
      @(posedge CLK); #2 RST = 1'b0;
      tick();
      run_block(1, 1, 0, upd, ivc, wkc, hc, ivn, wrf, wrl, pb, pd);
      check("rst_rerun_iv", ivc, 1);
      check("rst_rerun_dv", pd ? upd + 1 : -1, 68);
      release_done();

      // Random traffic, checked cycle by cycle by the model.
      for (int i = 0; i < 3000; i++) begin
         abort        = ($urandom_range(0, 199) == 0);
         blk_start    = ($urandom_range(0, 3) == 0);
         blk_first    = 1'($urandom);
         blk_last     = 1'($urandom);
         word_valid   = ($urandom_range(0, 3) != 0);
         digest_ready = ($urandom_range(0, 3) == 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
